// File: rtl/axi4_lat_sram_if.sv
// AXI4 read/write channel bundle between a requester (master) and the
// latency-programmable SRAM responder (slave).
// Signals: AR (arvalid/arready/arid/araddr/arlen/arsize/arburst),
//          R  (rvalid/rready/rid/rdata/rresp/rlast),
//          AW (awvalid/awready/awid/awaddr/awlen/awsize/awburst),
//          W  (wvalid/wready/wdata/wstrb/wlast),
//          B  (bvalid/bready/bid/bresp).
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high; the source holds valid and payload stable until then.
interface axi4_lat_sram_if;
  logic        in_arvalid;
  logic        in_arready;
  logic [3:0]  in_arid;
  logic [31:0] in_araddr;
  logic [7:0]  in_arlen;
  logic [2:0]  in_arsize;
  logic [1:0]  in_arburst;

  logic        in_rvalid;
  logic        in_rready;
  logic [3:0]  in_rid;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;

  logic        in_awvalid;
  logic        in_awready;
  logic [3:0]  in_awid;
  logic [31:0] in_awaddr;
  logic [7:0]  in_awlen;
  logic [2:0]  in_awsize;
  logic [1:0]  in_awburst;

  logic        in_wvalid;
  logic        in_wready;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_wlast;

  logic        in_bvalid;
  logic        in_bready;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;

  modport slave (
    input  in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
    output in_arready,
    output in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
    input  in_rready,
    input  in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
    output in_awready,
    input  in_wvalid, in_wdata, in_wstrb, in_wlast,
    output in_wready,
    output in_bvalid, in_bid, in_bresp,
    input  in_bready
  );

  modport master (
    output in_arvalid, in_arid, in_araddr, in_arlen, in_arsize, in_arburst,
    input  in_arready,
    input  in_rvalid, in_rid, in_rdata, in_rresp, in_rlast,
    output in_rready,
    output in_awvalid, in_awid, in_awaddr, in_awlen, in_awsize, in_awburst,
    input  in_awready,
    output in_wvalid, in_wdata, in_wstrb, in_wlast,
    input  in_wready,
    input  in_bvalid, in_bid, in_bresp,
    output in_bready
  );
endinterface

// File: rtl/axi4_lat_sram.sv
// AXI4 responder memory model with fixed, programmable read and write
// response latency. One outstanding transaction, 32-bit data, INCR/FIXED
// bursts, per-beat read response and worst-case write response.
// Ports:
//   clock       - single clock, rising edge
//   reset       - asynchronous, active-low (0 = in reset)
//   bus         - AXI4 slave side (AR/R/AW/W/B channels)
//   o_dbg_state - current FSM state encoding
// Handshake: every channel transfers on a rising edge where valid && ready;
// outputs held by this block (R payload, B payload) are stable while the
// corresponding ready is low.
module axi4_lat_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int R_LAT       = 4,
  parameter int W_LAT       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  axi4_lat_sram_if.slave         bus,
  output logic [2:0]             o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_R_WAIT = 3'd1,
    S_R_DATA = 3'd2,
    S_W_DATA = 3'd3,
    S_W_WAIT = 3'd4,
    S_B_RESP = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_id;
  logic [29:0] r_waddr;      // word address (byte address >> 2)
  logic [7:0]  r_len;
  logic [7:0]  r_beat;
  logic        r_incr;
  logic        r_slverr;
  logic [7:0]  r_cnt;
  logic [1:0]  r_bresp;

  logic [31:0] mem [DEPTH_WORDS];

  logic          w_last_beat;
  logic          w_oob;
  logic [1:0]    w_beat_resp;
  logic [1:0]    w_wresp;
  logic [1:0]    w_bresp_acc;
  logic [AW-1:0] w_idx;
  logic          w_mem_we;
  logic          w_unused_ok;

  assign w_last_beat = (r_beat == r_len);
  // Beyond-the-array test on the full word address, so aliasing of the low
  // index bits can never make an out-of-range beat look valid.
  assign w_oob       = ({1'b0, r_waddr} >= 31'(DEPTH_WORDS));
  assign w_idx       = r_waddr[AW-1:0];
  assign w_beat_resp = r_slverr ? 2'b10 : (w_oob ? 2'b11 : 2'b00);

  // A wlast that disagrees with the beat count is promoted to SLVERR; the
  // encodings OKAY < SLVERR < DECERR sort numerically, so max() gives "worst".
  assign w_wresp     = ((bus.in_wlast != w_last_beat) && (w_beat_resp == 2'b00))
                       ? 2'b10 : w_beat_resp;
  assign w_bresp_acc = (w_wresp > r_bresp) ? w_wresp : r_bresp;

  assign w_mem_we    = (r_state == S_W_DATA) && bus.in_wvalid && (w_beat_resp == 2'b00);

  assign w_unused_ok = ^{bus.in_araddr[1:0], bus.in_awaddr[1:0]};

  // Next-state and handshake outputs
  always_comb begin
    w_next         = r_state;
    bus.in_arready = 1'b0;
    bus.in_awready = 1'b0;
    bus.in_rvalid  = 1'b0;
    bus.in_wready  = 1'b0;
    bus.in_bvalid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_arready = 1'b1;
        bus.in_awready = !bus.in_arvalid;   // read wins a tie
        if (bus.in_arvalid)      w_next = S_R_WAIT;
        else if (bus.in_awvalid) w_next = S_W_DATA;
      end
      S_R_WAIT: begin
        if (r_cnt == 8'd0) w_next = S_R_DATA;
      end
      S_R_DATA: begin
        bus.in_rvalid = 1'b1;
        if (bus.in_rready && w_last_beat) w_next = S_IDLE;
      end
      S_W_DATA: begin
        bus.in_wready = 1'b1;
        if (bus.in_wvalid && w_last_beat) w_next = S_W_WAIT;
      end
      S_W_WAIT: begin
        if (r_cnt == 8'd0) w_next = S_B_RESP;
      end
      S_B_RESP: begin
        bus.in_bvalid = 1'b1;
        if (bus.in_bready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and transaction context
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_id     <= 4'd0;
      r_waddr  <= 30'd0;
      r_len    <= 8'd0;
      r_beat   <= 8'd0;
      r_incr   <= 1'b0;
      r_slverr <= 1'b0;
      r_cnt    <= 8'd0;
      r_bresp  <= 2'b00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_arvalid) begin
            r_id     <= bus.in_arid;
            r_waddr  <= bus.in_araddr[31:2];
            r_len    <= bus.in_arlen;
            r_beat   <= 8'd0;
            r_incr   <= (bus.in_arburst == 2'b01);
            r_slverr <= (bus.in_arsize != 3'd2) || bus.in_arburst[1];
            r_cnt    <= 8'(R_LAT);
          end else if (bus.in_awvalid) begin
            r_id     <= bus.in_awid;
            r_waddr  <= bus.in_awaddr[31:2];
            r_len    <= bus.in_awlen;
            r_beat   <= 8'd0;
            r_incr   <= (bus.in_awburst == 2'b01);
            r_slverr <= (bus.in_awsize != 3'd2) || bus.in_awburst[1];
            r_bresp  <= 2'b00;
          end
        end
        S_R_WAIT, S_W_WAIT: begin
          if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        S_R_DATA: begin
          if (bus.in_rready) begin
            r_beat <= r_beat + 8'd1;
            if (r_incr) r_waddr <= r_waddr + 30'd1;
          end
        end
        S_W_DATA: begin
          if (bus.in_wvalid) begin
            r_beat  <= r_beat + 8'd1;
            r_bresp <= w_bresp_acc;
            if (r_incr)      r_waddr <= r_waddr + 30'd1;
            if (w_last_beat) r_cnt   <= 8'(W_LAT);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory array: never reset, byte-lane write enables from wstrb
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.in_wstrb[b]) mem[w_idx][8*b +: 8] <= bus.in_wdata[8*b +: 8];
      end
    end
  end

  // R/B payload, forced to zero outside their data states
  assign bus.in_rdata = ((r_state == S_R_DATA) && (w_beat_resp == 2'b00)) ? mem[w_idx] : 32'h0;
  assign bus.in_rresp = (r_state == S_R_DATA) ? w_beat_resp : 2'b00;
  assign bus.in_rlast = (r_state == S_R_DATA) && w_last_beat;
  assign bus.in_rid   = r_id;
  assign bus.in_bid   = r_id;
  assign bus.in_bresp = (r_state == S_B_RESP) ? r_bresp : 2'b00;

  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_axi4_lat_sram.sv
// Directed testbench for axi4_lat_sram: bus-level drivers, expected-value
// queue for read beats, immediate assertions at every comparison point.
module tb_axi4_lat_sram;
  localparam int DEPTH = 1024;
  localparam int RL    = 4;
  localparam int WL    = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];   // {rlast, rresp, rdata}

  axi4_lat_sram_if bus();

  axi4_lat_sram #(.DEPTH_WORDS(DEPTH), .R_LAT(RL), .W_LAT(WL)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.in_arid = id; bus.in_araddr = addr; bus.in_arlen = len;
    bus.in_arsize = size; bus.in_arburst = burst; bus.in_arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_arready && n < 50) begin tick(); #1; n++; end
    chk("ar_ready_wait", 32'(n < 50), 32'd1);
    tick();
    bus.in_arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.in_awid = id; bus.in_awaddr = addr; bus.in_awlen = len;
    bus.in_awsize = size; bus.in_awburst = burst; bus.in_awvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_awready && n < 50) begin tick(); #1; n++; end
    chk("aw_ready_wait", 32'(n < 50), 32'd1);
    tick();
    bus.in_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    bus.in_wdata = data; bus.in_wstrb = strb; bus.in_wlast = last; bus.in_wvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_wready && n < 50) begin tick(); #1; n++; end
    chk("w_ready_wait", 32'(n < 50), 32'd1);
    tick();
    bus.in_wvalid = 1'b0;
  endtask

  // called right after the last W handshake edge
  task automatic b_check(input logic [3:0] id, input logic [1:0] resp);
    chk("b_early", 32'(bus.in_bvalid), 32'd0);
    for (int i = 0; i < WL; i++) begin
      tick();
      chk("b_early", 32'(bus.in_bvalid), 32'd0);
    end
    tick();
    chk("b_valid", 32'(bus.in_bvalid), 32'd1);
    chk("bresp", 32'(bus.in_bresp), 32'(resp));
    chk("bid", 32'(bus.in_bid), 32'(id));
    tick();
    chk("b_hold", 32'(bus.in_bvalid), 32'd1);
    chk("bresp_hold", 32'(bus.in_bresp), 32'(resp));
    bus.in_bready = 1'b1;
    tick();
    bus.in_bready = 1'b0;
    chk("b_done", 32'(bus.in_bvalid), 32'd0);
  endtask

  // called right after the AR handshake edge
  task automatic r_lat_check();
    chk("r_early", 32'(bus.in_rvalid), 32'd0);
    for (int i = 0; i < RL; i++) begin
      tick();
      chk("r_early", 32'(bus.in_rvalid), 32'd0);
    end
    tick();
    chk("r_valid", 32'(bus.in_rvalid), 32'd1);
  endtask

  task automatic push_r(input logic [31:0] data, input logic [1:0] resp, input logic last);
    exp_q.push_back({last, resp, data});
  endtask

  // scoreboard: drain the expected queue with rready held high
  task automatic r_collect(input logic [3:0] id);
    int budget;
    logic [34:0] e;
    budget = 700;
    bus.in_rready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (bus.in_rvalid) begin
        e = exp_q.pop_front();
        chk("rdata", bus.in_rdata, e[31:0]);
        chk("rresp", 32'(bus.in_rresp), 32'(e[33:32]));
        chk("rlast", 32'(bus.in_rlast), 32'(e[34]));
        chk("rid", 32'(bus.in_rid), 32'(id));
      end
      tick();
      budget--;
    end
    bus.in_rready = 1'b0;
    chk("r_beats_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("r_done", 32'(bus.in_rvalid), 32'd0);
  endtask

  task automatic wr1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data);
    aw_hs(id, addr, 8'd0, 3'd2, 2'b01);
    w_beat(data, 4'hF, 1'b1);
    b_check(id, 2'b00);
  endtask

  task automatic rd1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] resp);
    ar_hs(id, addr, 8'd0, 3'd2, 2'b01);
    r_lat_check();
    push_r(data, resp, 1'b1);
    r_collect(id);
  endtask

  logic [4:0] pat;
  logic [4:0] last_pat;

  initial begin
    bus.in_arvalid = 0; bus.in_arid = 0; bus.in_araddr = 0; bus.in_arlen = 0;
    bus.in_arsize = 0; bus.in_arburst = 0; bus.in_rready = 0;
    bus.in_awvalid = 0; bus.in_awid = 0; bus.in_awaddr = 0; bus.in_awlen = 0;
    bus.in_awsize = 0; bus.in_awburst = 0;
    bus.in_wvalid = 0; bus.in_wdata = 0; bus.in_wstrb = 0; bus.in_wlast = 0;
    bus.in_bready = 0;

    // reset state
    tick(); tick();
    chk("rst_arready", 32'(bus.in_arready), 32'd1);
    chk("rst_awready", 32'(bus.in_awready), 32'd1);
    chk("rst_rvalid", 32'(bus.in_rvalid), 32'd0);
    chk("rst_wready", 32'(bus.in_wready), 32'd0);
    chk("rst_bvalid", 32'(bus.in_bvalid), 32'd0);
    chk("rst_rlast", 32'(bus.in_rlast), 32'd0);
    chk("rst_rresp", 32'(bus.in_rresp), 32'd0);
    chk("rst_bresp", 32'(bus.in_bresp), 32'd0);
    chk("rst_rid", 32'(bus.in_rid), 32'd0);
    chk("rst_bid", 32'(bus.in_bid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    bus.in_arvalid = 1'b1;
    #1;
    chk("rst_awready_ar", 32'(bus.in_awready), 32'd0);
    bus.in_arvalid = 1'b0;
    #1;
    reset = 1'b1;
    tick();

    // preload through the bus
    wr1(4'd1, 32'h40,  32'hDEADBEEF);
    wr1(4'd1, 32'h108, 32'hA5A55A5A);
    wr1(4'd1, 32'h000, 32'h0BADF00D);
    wr1(4'd1, 32'hFFC, 32'h12345678);

    // single read, latency R_LAT+1 after handshake
    ar_hs(4'd3, 32'h40, 8'd0, 3'd2, 2'b01);
    r_lat_check();
    push_r(32'hDEADBEEF, 2'b00, 1'b1);
    r_collect(4'd3);

    // INCR write burst with partial strobe on beat 2
    aw_hs(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    w_beat(32'd1, 4'hF, 1'b0);
    w_beat(32'd2, 4'hF, 1'b0);
    w_beat(32'd3, 4'h3, 1'b0);
    w_beat(32'd4, 4'hF, 1'b1);
    b_check(4'd5, 2'b00);
    ar_hs(4'd6, 32'h100, 8'd3, 3'd2, 2'b01);
    r_lat_check();
    push_r(32'd1, 2'b00, 1'b0);
    push_r(32'd2, 2'b00, 1'b0);
    push_r(32'hA5A50003, 2'b00, 1'b0);
    push_r(32'd4, 2'b00, 1'b1);
    r_collect(4'd6);

    // FIXED read len=2 with rready 1,0,1,0,1
    ar_hs(4'd7, 32'h40, 8'd2, 3'd2, 2'b00);
    r_lat_check();
    pat      = 5'b10101;
    last_pat = 5'b11000;
    for (int i = 0; i < 5; i++) begin
      bus.in_rready = pat[i];
      chk("fix_rvalid", 32'(bus.in_rvalid), 32'd1);
      chk("fix_rdata", bus.in_rdata, 32'hDEADBEEF);
      chk("fix_rresp", 32'(bus.in_rresp), 32'd0);
      chk("fix_rlast", 32'(bus.in_rlast), 32'(last_pat[i]));
      chk("fix_rid", 32'(bus.in_rid), 32'd7);
      tick();
    end
    bus.in_rready = 1'b0;
    chk("fix_done", 32'(bus.in_rvalid), 32'd0);

    // bad size -> SLVERR, zero data
    ar_hs(4'd8, 32'h40, 8'd0, 3'd1, 2'b01);
    r_lat_check();
    push_r(32'h0, 2'b10, 1'b1);
    r_collect(4'd8);

    // write crossing the top of memory -> DECERR, second beat dropped
    aw_hs(4'd9, 32'hFFC, 8'd1, 3'd2, 2'b01);
    w_beat(32'h11111111, 4'hF, 1'b0);
    w_beat(32'h22222222, 4'hF, 1'b1);
    b_check(4'd9, 2'b11);
    rd1(4'd10, 32'hFFC,  32'h11111111, 2'b00);
    rd1(4'd10, 32'h000,  32'h0BADF00D, 2'b00);
    rd1(4'd10, 32'h1000, 32'h0,        2'b11);

    // wlast mismatch -> SLVERR, data still written
    aw_hs(4'd2, 32'h300, 8'd0, 3'd2, 2'b01);
    w_beat(32'h55AA55AA, 4'hF, 1'b0);
    b_check(4'd2, 2'b10);
    rd1(4'd2, 32'h300, 32'h55AA55AA, 2'b00);

    // AR and AW together: read first, write held off
    bus.in_arid = 4'd4; bus.in_araddr = 32'h40; bus.in_arlen = 8'd0;
    bus.in_arsize = 3'd2; bus.in_arburst = 2'b01;
    bus.in_awid = 4'hC; bus.in_awaddr = 32'h200; bus.in_awlen = 8'd0;
    bus.in_awsize = 3'd2; bus.in_awburst = 2'b01;
    bus.in_arvalid = 1'b1; bus.in_awvalid = 1'b1;
    #1;
    chk("col_arready", 32'(bus.in_arready), 32'd1);
    chk("col_awready", 32'(bus.in_awready), 32'd0);
    tick();
    bus.in_arvalid = 1'b0;
    for (int i = 0; i <= RL; i++) begin
      chk("col_awready_wait", 32'(bus.in_awready), 32'd0);
      chk("col_rvalid_early", 32'(bus.in_rvalid), 32'd0);
      tick();
    end
    chk("col_awready_rdata", 32'(bus.in_awready), 32'd0);
    push_r(32'hDEADBEEF, 2'b00, 1'b1);
    r_collect(4'd4);
    chk("col_awready_idle", 32'(bus.in_awready), 32'd1);
    tick();
    bus.in_awvalid = 1'b0;
    w_beat(32'hCAFEF00D, 4'hF, 1'b1);
    b_check(4'hC, 2'b00);
    rd1(4'd4, 32'h200, 32'hCAFEF00D, 2'b00);

    // arlen=255: 256 beats, rlast only on the final one
    ar_hs(4'd1, 32'h40, 8'd255, 3'd2, 2'b00);
    r_lat_check();
    for (int i = 0; i < 256; i++) push_r(32'hDEADBEEF, 2'b00, 1'(i == 255));
    r_collect(4'd1);

    // async reset in the middle of R_DATA
    ar_hs(4'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    r_lat_check();
    tick();
    chk("mid_stall_rvalid", 32'(bus.in_rvalid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.in_rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.in_arready), 32'd1);
    #2 reset = 1'b1;
    tick();
    chk("post_rst_arready", 32'(bus.in_arready), 32'd1);
    chk("post_rst_rvalid", 32'(bus.in_rvalid), 32'd0);
    rd1(4'd6, 32'h100, 32'd1, 2'b00);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
